// File: rtl/sram_blwl_prog_pkg.sv
// Shared types and constants for the BL/WL configuration-row programmer.
package sram_blwl_prog_pkg;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        SETUP     = 3'd2,
        PULSE     = 3'd3,
        HOLD      = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/sram_blwl_prog_timer.sv
// Loadable down-counter with a zero flag; reloaded once per programming phase.
module sram_blwl_prog_timer
    import sram_blwl_prog_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero_c
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/sram_blwl_programmer.sv
// Row-at-a-time BL/WL configuration-memory writer with setup/pulse/hold timing.
// Optional readback verify enabled by defining SRAM_BLWL_PROG_VERIFY_EN.
module sram_blwl_programmer
    import sram_blwl_prog_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 16,
    parameter int unsigned NUM_COLS = 32,
    parameter int unsigned ROW_W    = 4,
    parameter int unsigned BL_SETUP = 1,
    parameter int unsigned WL_PULSE = 2,
    parameter int unsigned BL_HOLD  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [NUM_COLS-1:0] wr_data,
    output logic [0:NUM_COLS-1] bl,
    output logic [0:NUM_ROWS-1] wl,
    output logic [ROW_W-1:0]    row,
    output logic                busy,
    output logic                done
`ifdef SRAM_BLWL_PROG_VERIFY_EN
    ,
    input  logic [NUM_COLS-1:0] rb_data,
    output logic                verify_err,
    output logic [ROW_W-1:0]    err_row
`endif
);

    state_t               state, state_d;
    logic [NUM_COLS-1:0]  bl_q, bl_d;
    logic [NUM_ROWS-1:0]  wl_q, wl_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_val;
    logic                 tmr_zero_c;
    logic                 last_row_c;

    assign last_row_c = (row_q == ROW_W'(NUM_ROWS - 1));

    sram_blwl_prog_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, phase timer reloads and next values of the line drivers.
    always_comb begin
        state_d  = state;
        bl_d     = bl_q;
        wl_d     = wl_q;
        row_d    = row_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_DATA;
                    row_d   = '0;
                end
            end
            WAIT_DATA: begin
                if (wr_valid && wr_ready) begin
                    bl_d     = wr_data;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(BL_SETUP - 1);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero_c) begin
                    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                        wl_d[r] = (row_q == ROW_W'(r));
                    end
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(WL_PULSE - 1);
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (tmr_zero_c) begin
                    wl_d     = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(BL_HOLD - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero_c) begin
                    bl_d = '0;
                    if (last_row_c) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                row_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over everything else, including a handshake in this cycle.
        if (abort && (state != IDLE)) begin
            state_d  = IDLE;
            bl_d     = '0;
            wl_d     = '0;
            row_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bl_q     <= '0;
            wl_q     <= '0;
            row_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            bl_q     <= bl_d;
            wl_q     <= wl_d;
            row_q    <= row_d;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            wr_ready <= (state_d == WAIT_DATA);
        end
    end

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_bl
        assign bl[i] = bl_q[i];
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_wl
        assign wl[r] = wl_q[r];
    end

    assign row = row_q;

`ifdef SRAM_BLWL_PROG_VERIFY_EN
    // Sticky readback mismatch flag; err_row keeps the first failing row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_err <= 1'b0;
            err_row    <= '0;
        end else if ((state == IDLE) && start) begin
            verify_err <= 1'b0;
            err_row    <= '0;
        end else if ((state == HOLD) && tmr_zero_c && !abort && (rb_data != bl_q)) begin
            verify_err <= 1'b1;
            if (!verify_err) begin
                err_row <= row_q;
            end
        end
    end
`endif

endmodule
